// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and op classification for the sequential ALU.
package alu_pkg;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0011;
    localparam logic [3:0] ALU_SLL   = 4'b0100;
    localparam logic [3:0] ALU_SRL   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;
    localparam logic [3:0] ALU_SRA   = 4'b0111;
    localparam logic [3:0] ALU_SLT   = 4'b1000;
    localparam logic [3:0] ALU_SLTU  = 4'b1001;
    localparam logic [3:0] ALU_MUL   = 4'b1010;
    localparam logic [3:0] ALU_MULHU = 4'b1011;
    localparam logic [3:0] ALU_DIVU  = 4'b1100;
    localparam logic [3:0] ALU_REMU  = 4'b1101;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_e;

    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == ALU_MUL) || (op == ALU_MULHU) || (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == ALU_DIVU) || (op == ALU_REMU);
    endfunction

    // MULHU and REMU both read the upper/remainder register of the iterator.
    function automatic logic is_hi_result(input logic [3:0] op);
        return (op == ALU_MULHU) || (op == ALU_REMU);
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle between the execute stage and the sequential ALU.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic [3:0]       ALU_control;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] ALU_result;
    logic             Zero;
    logic             Neg;
    logic             Ovf;
    logic             Busy;

    modport master (
        output in_valid, A, B, ALU_control, out_ready,
        input  in_ready, out_valid, ALU_result, Zero, Neg, Ovf, Busy
    );

    modport slave (
        input  in_valid, A, B, ALU_control, out_ready,
        output in_ready, out_valid, ALU_result, Zero, Neg, Ovf, Busy
    );
endinterface

// File: rtl/alu_muldiv_iter.sv
// Iterative unsigned multiply (shift-add) and restoring divide, one step per clock,
// WIDTH steps per operation regardless of operand values.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    logic             running_q;
    logic [CW-1:0]    cnt_q;
    logic             is_div_q;
    logic             sel_hi_q;
    // mul: m = multiplicand, {hi,lo} = product with multiplier shifting out of lo
    // div: m = divisor, hi = partial remainder, lo = dividend in / quotient out
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;

    always_comb begin
        hi_d    = hi_q;
        lo_d    = lo_q;
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        // Only consumed when shifted >= m, so the dropped borrow bit is always zero.
        diff    = shifted[WIDTH-1:0] - m_q;
        if (is_div_q) begin
            if (shifted >= {1'b0, m_q}) begin
                hi_d = diff;
                lo_d = {lo_q[WIDTH-2:0], 1'b1};
            end else begin
                hi_d = shifted[WIDTH-1:0];
                lo_d = {lo_q[WIDTH-2:0], 1'b0};
            end
        end else begin
            hi_d = sum[WIDTH:1];
            lo_d = {sum[0], lo_q[WIDTH-1:1]};
        end
    end

    // Result is taken from the final step's next-state so the top can register it
    // on the same edge that retires the last iteration.
    assign done   = running_q && (cnt_q == LAST_STEP);
    assign result = sel_hi_q ? hi_d : lo_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            running_q <= 1'b0;
            cnt_q     <= '0;
            is_div_q  <= 1'b0;
            sel_hi_q  <= 1'b0;
            m_q       <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else if (start) begin
            running_q <= 1'b1;
            cnt_q     <= '0;
            is_div_q  <= is_div(op);
            sel_hi_q  <= is_hi_result(op);
            m_q       <= is_div(op) ? b : a;
            hi_q      <= '0;
            lo_q      <= is_div(op) ? a : b;
        end else if (running_q) begin
            hi_q  <= hi_d;
            lo_q  <= lo_d;
            cnt_q <= cnt_q + 1'b1;
            if (done) begin
                running_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Multi-cycle execute-stage ALU: single-cycle logic/arith/shift/compare ops plus
// optional iterative MUL/MULHU/DIVU/REMU, with valid/ready on both sides.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MULDIV_EN = 1'b1
) (
    input  logic     clk,
    input  logic     rst,
    alu_seq_if.slave bus
);

    localparam int unsigned SHW = $clog2(WIDTH);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;
    logic             neg_q, neg_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             long_op;
    logic             md_start;
    logic             md_done;
    logic [WIDTH-1:0] md_result;

    logic [SHW-1:0]   shamt;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] diff;
    logic [WIDTH-1:0] sc_result;
    logic             sc_ovf;

    assign accept   = bus.in_valid && (state_q == S_IDLE);
    assign long_op  = MULDIV_EN && is_multicycle(bus.ALU_control);
    assign md_start = accept && long_op;

    always_comb begin
        shamt     = bus.B[SHW-1:0];
        sum       = bus.A + bus.B;
        diff      = bus.A - bus.B;
        sc_result = bus.A;
        sc_ovf    = 1'b0;
        case (bus.ALU_control)
            ALU_AND:  sc_result = bus.A & bus.B;
            ALU_OR:   sc_result = bus.A | bus.B;
            ALU_XOR:  sc_result = bus.A ^ bus.B;
            ALU_ADD: begin
                sc_result = sum;
                sc_ovf    = (bus.A[WIDTH-1] == bus.B[WIDTH-1]) &&
                            (sum[WIDTH-1] != bus.A[WIDTH-1]);
            end
            ALU_SUB: begin
                sc_result = diff;
                sc_ovf    = (bus.A[WIDTH-1] != bus.B[WIDTH-1]) &&
                            (diff[WIDTH-1] != bus.A[WIDTH-1]);
            end
            ALU_SLL:  sc_result = bus.A << shamt;
            ALU_SRL:  sc_result = bus.A >> shamt;
            ALU_SRA:  sc_result = $unsigned($signed(bus.A) >>> shamt);
            ALU_SLT:  sc_result = {{(WIDTH-1){1'b0}}, $signed(bus.A) < $signed(bus.B)};
            ALU_SLTU: sc_result = {{(WIDTH-1){1'b0}}, bus.A < bus.B};
            default:  sc_result = bus.A;
        endcase
    end

    alu_muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .start (md_start),
        .op    (bus.ALU_control),
        .a     (bus.A),
        .b     (bus.B),
        .result(md_result),
        .done  (md_done)
    );

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        zero_d   = zero_q;
        neg_d    = neg_q;
        ovf_d    = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (long_op) begin
                        state_d = S_CALC;
                    end else begin
                        result_d = sc_result;
                        zero_d   = (sc_result == '0);
                        neg_d    = sc_result[WIDTH-1];
                        ovf_d    = sc_ovf;
                        state_d  = S_DONE;
                    end
                end
            end
            S_CALC: begin
                if (md_done) begin
                    result_d = md_result;
                    zero_d   = (md_result == '0);
                    neg_d    = md_result[WIDTH-1];
                    ovf_d    = 1'b0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                // Returning through IDLE forbids a re-accept on the handshake cycle.
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            result_q <= '0;
            zero_q   <= 1'b0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            neg_q    <= neg_d;
            ovf_q    <= ovf_d;
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE);
    assign bus.out_valid  = (state_q == S_DONE);
    assign bus.Busy       = (state_q != S_IDLE);
    assign bus.ALU_result = result_q;
    assign bus.Zero       = zero_q;
    assign bus.Neg        = neg_q;
    assign bus.Ovf        = ovf_q;

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
Parametrised, multi-cycle successor to the single-cycle datapath ALU. It keeps the existing 4-bit op encoding for AND/OR/ADD/SUB and adds shifts, compares, and iterative unsigned multiply and divide. Operands are accepted and results returned over valid/ready handshakes. It sits in the execute stage and lets the pipeline stall on long operations.

Parameters:
WIDTH  32  operand/result width; power of 2, >= 8
MULDIV_EN  1  1 = MUL/MULHU/DIVU/REMU implemented; 0 = those ops take the default path (result = A)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  operands/op presented
in_ready  out  1  block can accept an operation
A  in  WIDTH  operand A
B  in  WIDTH  operand B
ALU_control  in  4  opcode, sampled on accept
out_valid  out  1  result registers valid
out_ready  in  1  consumer takes result
ALU_result  out  WIDTH  result
Zero  out  1  ALU_result == 0
Neg  out  1  ALU_result[WIDTH-1]
Ovf  out  1  signed overflow (ADD/SUB only, else 0)
Busy  out  1  state != IDLE

Behaviour:
- Reset: at the rising edge with rst=1, the state goes to IDLE. ALU_result=0, Zero=0, Neg=0, Ovf=0, out_valid=0. in_ready is 1 the cycle after reset deasserts.
- rst asserted mid-operation aborts the operation. Nothing in flight is delivered.
- Accept: an operation is accepted when in_valid && in_ready. in_ready = (state==IDLE). A, B and ALU_control are captured on accept.
- Opcodes:
  - 0000 AND; 0001 OR; 0010 ADD; 0110 SUB; 0011 XOR
  - 0100 SLL; 0101 SRL; 0111 SRA
  - 1000 SLT (signed, result 0/1); 1001 SLTU
  - 1010 MUL (low WIDTH bits); 1011 MULHU (high WIDTH bits)
  - 1100 DIVU; 1101 REMU
  - all others: result = A
- Shifts use B[log2(WIDTH)-1:0] only.
- Zero is always (result==0), for every op, including SUB with A==B. The old quirk of leaving the result stale is removed.
- State machine IDLE -> CALC -> DONE -> IDLE:
  - IDLE: on accept of a single-cycle op, compute and register the result, then go to DONE. out_valid is 1 the cycle after accept (latency 1).
  - IDLE: on accept of MUL/MULHU/DIVU/REMU (MULDIV_EN=1), load the iteration registers, clear the counter, go to CALC.
  - CALC: one shift-add (mul) or restoring shift-subtract (div) step per cycle. After exactly WIDTH steps, write the result and go to DONE. Total latency from accept to out_valid = WIDTH+1 cycles (33 for WIDTH=32).
  - DONE: out_valid=1. ALU_result and flags hold stable until out_ready=1. On out_ready, go to IDLE. There is no same-cycle re-accept: the next accept is earliest one cycle after the handshake.
- Multiply: 2*WIDTH-bit unsigned product. MUL returns the low half, MULHU the high half.
- Divide by zero (B==0), per RV32M:
  - DIVU = all ones; REMU = A.
  - It still takes WIDTH+1 cycles so timing is data-independent.
- Ovf:
  - ADD: A and B have the same sign and the result sign differs.
  - SUB: A and B have different signs and the result sign differs from A.
- in_valid while not in IDLE is ignored. The source must hold its data until in_ready.
- out_ready while out_valid=0 has no effect.

Decomposition:
- Package alu_pkg: opcode localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA, ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULHU, ALU_DIVU, ALU_REMU), the state encoding (S_IDLE, S_CALC, S_DONE), and a function is_multicycle(op).
- One sub-module, alu_muldiv_iter: handles the iterative mul/div datapath, the step counter and done pulse, with start/op/A/B in and result/done out. The top holds the FSM, handshakes, single-cycle ops and flags.

Test Plan:
- Reset mid-DIVU: accept DIVU 100/7, assert rst at cycle 10 -> out_valid stays 0, ALU_result=0; the next ADD 1+2 returns 3 with out_valid one cycle after accept.
- Single-cycle with backpressure: SUB 5-5 with out_ready=0 for 4 cycles -> ALU_result=0 and Zero=1 held stable; in_ready=0 until the handshake; ADD 0x7FFFFFFF+1 -> 0x80000000, Ovf=1, Neg=1.
- Multiply: MUL 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001; MULHU of the same -> 0xFFFFFFFE; out_valid exactly 33 cycles after accept, Busy=1 throughout.
- Divide: DIVU 100/7 -> 14; REMU 100/7 -> 2; DIVU 5/0 -> 0xFFFFFFFF; REMU 5/0 -> 5; all at latency 33.
- Shifts/compares: SRA 0x80000000 by B=0x21 -> 0xC0000000 (shift amount 1); SLT -1,1 -> 1; SLTU -1,1 -> 0; opcode 1111 with A=0x1234 -> 0x1234.
- Back-to-back and parameter corner:
  - Stream 3 ops with out_ready=1 and in_valid held -> each result delivered in order, and no accept in the same cycle as an output handshake.
  - Rerun the MUL and DIV scenarios with WIDTH=8 -> latency 9.
  - With MULDIV_EN=0, MUL returns A in 1 cycle.
